i2c_config_seq: RTL and testbench

I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

---
 rtl/i2c_config_seq_pkg.sv | 30 +++
 rtl/i2c_config_seq_cfg_rom.sv | 42 ++++
 rtl/i2c_config_seq.sv | 145 ++++++++++++++
 tb/tb_i2c_config_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_config_seq_pkg.sv
// Shared types for the HDMI transmitter init sequencer: FSM encoding,
// default slave address and the {sub-address, data} table entry format.
package i2c_config_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LOAD,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [7:0] DEFAULT_SLAVE_ADDR = 8'h72;

    typedef struct packed {
        logic [7:0] sub_addr;
        logic [7:0] data;
    } cfg_entry_t;

    function automatic cfg_entry_t cfg(input logic [7:0] sub_addr, input logic [7:0] data);
        cfg_entry_t e;
        e.sub_addr = sub_addr;
        e.data     = data;
        return e;
    endfunction

endpackage

// File: rtl/i2c_config_seq_cfg_rom.sv
// Combinational init table for the HDMI transmitter; entries at or beyond
// NUM_REGS read as zero.
module i2c_cfg_rom
    import i2c_config_seq_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [5:0] addr_i,
    output cfg_entry_t entry_o
);

    localparam logic [6:0] NUM_ENTRIES = 7'(NUM_REGS);

    cfg_entry_t table_entry;

    always_comb begin
        // NOTE: default assigned before the case so no path leaves table_entry unassigned (no latch).
        table_entry = cfg(8'h00, 8'h00);
        case (addr_i)
            6'd0:    table_entry = cfg(8'h41, 8'h10);
            6'd1:    table_entry = cfg(8'h98, 8'h03);
            6'd2:    table_entry = cfg(8'h9A, 8'hE0);
            6'd3:    table_entry = cfg(8'h9C, 8'h30);
            6'd4:    table_entry = cfg(8'h9D, 8'h61);
            6'd5:    table_entry = cfg(8'hA2, 8'hA4);
            6'd6:    table_entry = cfg(8'hA3, 8'hA4);
            6'd7:    table_entry = cfg(8'hE0, 8'hD0);
            6'd8:    table_entry = cfg(8'hF9, 8'h00);
            6'd9:    table_entry = cfg(8'h15, 8'h00);
            6'd10:   table_entry = cfg(8'h16, 8'h30);
            6'd11:   table_entry = cfg(8'h18, 8'h46);
            6'd12:   table_entry = cfg(8'h40, 8'h80);
            6'd13:   table_entry = cfg(8'h48, 8'h08);
            6'd14:   table_entry = cfg(8'h55, 8'h00);
            6'd15:   table_entry = cfg(8'hAF, 8'h06);
            default: table_entry = cfg(8'h00, 8'h00);
        endcase
    end

    assign entry_o = ({1'b0, addr_i} < NUM_ENTRIES) ? table_entry : cfg(8'h00, 8'h00);

endmodule

// File: rtl/i2c_config_seq.sv
// Power-up register init sequencer: walks the init table and issues one
// I2C write per entry, with per-attempt timeout and bounded retries.
module i2c_config_seq
    import i2c_config_seq_pkg::*;
#(
    parameter int         NUM_REGS       = 16,
    parameter logic [7:0] SLAVE_ADDR     = DEFAULT_SLAVE_ADDR,
    parameter int         SETTLE_CYCLES  = 1000,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        i2c_done,
    input  logic        i2c_ack_err,
    output logic        i2c_go,
    output logic [23:0] i2c_data,
    output logic        busy,
    output logic        config_done,
    output logic        error,
    output logic [5:0]  reg_index
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'((SETTLE_CYCLES  > 0) ? SETTLE_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(MAX_RETRY);
    localparam logic [5:0]       LAST_IDX     = 6'(NUM_REGS - 1);
    localparam state_t           RUN_ENTRY    = (SETTLE_CYCLES == 0) ? S_LOAD : S_SETTLE;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         idx_q, idx_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [23:0]        data_q, data_d;
    logic               go_q, go_d;
    logic               pass_q, pass_d;
    cfg_entry_t         rom_entry;

    i2c_cfg_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .addr_i  (idx_q),
        .entry_o (rom_entry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        data_d  = data_q;
        pass_d  = pass_q;
        // The go pulse is registered, so it lands the cycle after LAUNCH.
        go_d    = (state_q == S_LAUNCH);

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d = RUN_ENTRY;
                    cnt_d   = '0;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOAD: begin
                data_d  = {SLAVE_ADDR, rom_entry};
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i2c_done) begin
                    pass_d  = ~i2c_ack_err;
                    state_d = S_CHECK;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    pass_d  = 1'b0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (pass_q) begin
                    retry_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_LOAD;
                    end
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_FAIL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            data_q  <= '0;
            go_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            data_q  <= data_d;
            go_q    <= go_d;
            pass_q  <= pass_d;
        end
    end

    assign i2c_go      = go_q;
    assign i2c_data    = data_q;
    assign reg_index   = idx_q;
    assign config_done = (state_q == S_DONE);
    assign error       = (state_q == S_FAIL);
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);

endmodule

// File: tb/tb_i2c_config_seq.sv
// Directed bench for i2c_config_seq with a simple I2C writer model that
// acks, NACKs a chosen entry a set number of times, or never answers.
module tb_i2c_config_seq;

    localparam int SETTLE = 10;
    localparam int NREGS  = 4;
    localparam int TMO    = 50;
    localparam int WR_LAT = 3;

    logic        clk = 1'b0;
    logic        reset, start, i2c_done, i2c_ack_err;
    logic        i2c_go, busy, config_done, error;
    logic [23:0] i2c_data;
    logic [5:0]  reg_index;

    int checks = 0;
    int errors = 0;

    int          cyc, go_count, pending, nack_entry, nack_left;
    bit          never_done, hold_start, spur_en;
    logic [23:0] data_log [16];
    int          cyc_log  [16];
    logic [5:0]  idx_log  [16];

    always #5 clk = ~clk;

    i2c_config_seq #(
        .NUM_REGS       (NREGS),
        .SLAVE_ADDR     (8'h72),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .i2c_done    (i2c_done),
        .i2c_ack_err (i2c_ack_err),
        .i2c_go      (i2c_go),
        .i2c_data    (i2c_data),
        .busy        (busy),
        .config_done (config_done),
        .error       (error),
        .reg_index   (reg_index)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample just after the edge, log gos, then drive the writer response.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        i2c_done    = 1'b0;
        i2c_ack_err = 1'b0;
        if (i2c_go) begin
            if (go_count < 16) begin
                data_log[go_count] = i2c_data;
                cyc_log[go_count]  = cyc;
                idx_log[go_count]  = reg_index;
            end
            go_count++;
            pending = WR_LAT;
        end else if (pending > 0) begin
            pending--;
            if (pending == 0 && !never_done) begin
                i2c_done = 1'b1;
                if (int'(reg_index) == nack_entry && nack_left > 0) begin
                    i2c_ack_err = 1'b1;
                    nack_left--;
                end
            end
        end
        if (spur_en && cyc >= 2 && cyc <= 6) begin
            i2c_done    = 1'b1;
            i2c_ack_err = 1'b0;
        end
        if (!hold_start || go_count >= 2) start = 1'b0;
    endtask

    task automatic start_run(input int nack_e, input int nack_n, input bit nd,
                             input bit hold, input bit spur);
        nack_entry = nack_e;
        nack_left  = nack_n;
        never_done = nd;
        hold_start = hold;
        spur_en    = spur;
        go_count   = 0;
        pending    = 0;
        cyc        = 0;
        start      = 1'b1;
    endtask

    task automatic run_to_end(input string tag, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(config_done || error) && n < budget);
        check({tag, "_end"}, {31'd0, config_done | error}, 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        i2c_done    = 1'b0;
        i2c_ack_err = 1'b0;
        cyc = 0; go_count = 0; pending = 0; nack_entry = -1; nack_left = 0;
        never_done = 1'b0; hold_start = 1'b0; spur_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_go", {31'd0, i2c_go}, 32'd0);
        check("rst_done", {31'd0, config_done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_index", {26'd0, reg_index}, 32'd0);
        check("rst_data", {8'd0, i2c_data}, 32'd0);

        @(negedge clk) reset = 1'b0;
        repeat (5) tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_gos", go_count, 0);

        // A: writer always acks
        start_run(-1, 0, 1'b0, 1'b0, 1'b0);
        run_to_end("A", 300);
        check("A_first_go_cyc", cyc_log[0], SETTLE + 3);
        check("A_gos", go_count, NREGS);
        check("A_data0", {8'd0, data_log[0]}, 32'h0072_4110);
        check("A_data1", {8'd0, data_log[1]}, 32'h0072_9803);
        check("A_data2", {8'd0, data_log[2]}, 32'h0072_9AE0);
        check("A_data3", {8'd0, data_log[3]}, 32'h0072_9C30);
        check("A_done", {31'd0, config_done}, 32'd1);
        check("A_error", {31'd0, error}, 32'd0);
        check("A_busy", {31'd0, busy}, 32'd0);
        check("A_index", {26'd0, reg_index}, 32'd3);

        // B: entry 2 NACKed twice, restart from DONE
        start_run(2, 2, 1'b0, 1'b0, 1'b0);
        tick();
        check("B_restart_done", {31'd0, config_done}, 32'd0);
        check("B_restart_busy", {31'd0, busy}, 32'd1);
        check("B_restart_index", {26'd0, reg_index}, 32'd0);
        run_to_end("B", 400);
        check("B_gos", go_count, NREGS + 2);
        check("B_retry_data_a", {8'd0, data_log[3]}, 32'h0072_9AE0);
        check("B_retry_data_b", {8'd0, data_log[4]}, 32'h0072_9AE0);
        check("B_retry_index", {26'd0, idx_log[4]}, 32'd2);
        check("B_last_data", {8'd0, data_log[5]}, 32'h0072_9C30);
        check("B_done", {31'd0, config_done}, 32'd1);

        // C: entry 1 NACKed four times -> FAIL
        start_run(1, 4, 1'b0, 1'b0, 1'b0);
        run_to_end("C", 400);
        check("C_error", {31'd0, error}, 32'd1);
        check("C_done", {31'd0, config_done}, 32'd0);
        check("C_index", {26'd0, reg_index}, 32'd1);
        check("C_busy", {31'd0, busy}, 32'd0);
        check("C_gos", go_count, 5);
        repeat (20) tick();
        check("C_gos_after", go_count, 5);
        check("C_error_hold", {31'd0, error}, 32'd1);

        // D: writer never answers -> four timed-out attempts
        start_run(-1, 0, 1'b1, 1'b0, 1'b0);
        run_to_end("D", 400);
        check("D_error", {31'd0, error}, 32'd1);
        check("D_gos", go_count, 4);
        for (int k = 0; k < 3; k++)
            check($sformatf("D_spacing%0d", k), cyc_log[k + 1] - cyc_log[k], TMO + 2);
        check("D_fail_cyc", cyc, cyc_log[3] + TMO + 1);
        check("D_index", {26'd0, reg_index}, 32'd0);

        // E: reset during WAIT of entry 2, then a clean restart
        start_run(-1, 0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 300 && go_count < 3; n++) tick();
        tick();
        check("E_pre_index", {26'd0, reg_index}, 32'd2);
        check("E_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("E_rst_busy", {31'd0, busy}, 32'd0);
        check("E_rst_go", {31'd0, i2c_go}, 32'd0);
        check("E_rst_data", {8'd0, i2c_data}, 32'd0);
        check("E_rst_index", {26'd0, reg_index}, 32'd0);
        check("E_rst_flags", {30'd0, config_done, error}, 32'd0);
        pending = 0;
        @(negedge clk) reset = 1'b0;
        repeat (3) tick();
        check("E_quiet_busy", {31'd0, busy}, 32'd0);
        check("E_quiet_gos", go_count, 3);
        start_run(-1, 0, 1'b0, 1'b0, 1'b0);
        run_to_end("E", 300);
        check("E_first_go_cyc", cyc_log[0], SETTLE + 3);
        check("E_first_index", {26'd0, idx_log[0]}, 32'd0);
        check("E_first_data", {8'd0, data_log[0]}, 32'h0072_4110);
        check("E_gos", go_count, NREGS);
        check("E_done", {31'd0, config_done}, 32'd1);

        // F: start held high during the run, spurious done during SETTLE
        start_run(-1, 0, 1'b0, 1'b1, 1'b1);
        run_to_end("F", 300);
        check("F_first_go_cyc", cyc_log[0], SETTLE + 3);
        check("F_first_index", {26'd0, idx_log[0]}, 32'd0);
        check("F_second_index", {26'd0, idx_log[1]}, 32'd1);
        check("F_gos", go_count, NREGS);
        check("F_done", {31'd0, config_done}, 32'd1);
        repeat (10) tick();
        check("F_idle_busy", {31'd0, busy}, 32'd0);
        check("F_gos_after", go_count, NREGS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
